// File: rtl/scalar_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback sources, the register-file write port,
// and the issue/operand lookups into the busy scoreboard.
interface scalar_wb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              s0_valid;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dst;
    logic              iss_ready;

    logic [ADDR_W-1:0] chk_rs1;
    logic [ADDR_W-1:0] chk_rs2;
    logic              hazard;

    // Arbiter side.
    modport slave (
        input  s0_valid, s0_addr, s0_data,
        output s0_ready,
        input  s1_valid, s1_addr, s1_data,
        output s1_ready,
        output wr_en, wr_addr, wr_data,
        input  iss_valid, iss_dst,
        output iss_ready,
        input  chk_rs1, chk_rs2,
        output hazard
    );

    // Pipeline side: writeback sources, decode, register file.
    modport master (
        output s0_valid, s0_addr, s0_data,
        input  s0_ready,
        output s1_valid, s1_addr, s1_data,
        input  s1_ready,
        input  wr_en, wr_addr, wr_data,
        output iss_valid, iss_dst,
        input  iss_ready,
        output chk_rs1, chk_rs2,
        input  hazard
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Round-robin arbiter for the scalar register file write port (src0 = ALU,
// src1 = memory load) with a per-register busy scoreboard for decode stalls.
module scalar_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    scalar_wb_arbiter_if.slave bus
);
    typedef enum logic {
        GRANT_S0 = 1'b0,
        GRANT_S1 = 1'b1
    } grant_e;

    grant_e           last_grant;
    grant_e           last_grant_next;
    logic             s0_take;
    logic             s1_take;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             issue_fire;

    // Grant selection and pointer update; idle cycles leave the pointer alone.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        s0_take         = 1'b0;
        s1_take         = 1'b0;
        last_grant_next = last_grant;
        if (bus.s0_valid && bus.s1_valid) begin
            if (last_grant == GRANT_S1) s0_take = 1'b1;
            else                        s1_take = 1'b1;
        end else if (bus.s0_valid) begin
            s0_take = 1'b1;
        end else if (bus.s1_valid) begin
            s1_take = 1'b1;
        end
        if (s0_take)      last_grant_next = GRANT_S0;
        else if (s1_take) last_grant_next = GRANT_S1;
    end

    // A grant is only ever given to a valid source, so ready equals grant.
    assign bus.s0_ready = s0_take;
    assign bus.s1_ready = s1_take;

    // Arbitration pointer; reset hands src0 the first win.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
        if (reset) last_grant <= GRANT_S1;
        else       last_grant <= last_grant_next;
    end

    // Registered write port: accepted transfer appears one cycle later; addr/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= s0_take | s1_take;
            if (s0_take) begin
                bus.wr_addr <= bus.s0_addr;
                bus.wr_data <= bus.s0_data;
            end else if (s1_take) begin
                bus.wr_addr <= bus.s1_addr;
                bus.wr_data <= bus.s1_data;
            end
        end
    end

    assign bus.iss_ready = ~busy[bus.iss_dst];
    assign issue_fire    = bus.iss_valid & bus.iss_ready;
    assign bus.hazard    = busy[bus.chk_rs1] | busy[bus.chk_rs2];

    // Scoreboard next state: commit clears first, a new issue sets afterwards so set wins.
    always_comb begin
        busy_next = busy;
        if (bus.wr_en) busy_next[bus.wr_addr] = 1'b0;
        if (issue_fire) busy_next[bus.iss_dst] = 1'b1;
    end

    // Busy flags are control state, not register-file storage, so reset clears them all.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this small flag vector is reset deliberately; the register-file data array itself is never reset.
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares each wr_en pulse.
module tb_scalar_wb_arbiter;
    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    scalar_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    scalar_wb_arbiter #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b0 && bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("wr_data", 32'(bus.wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] grants;
        bus.s0_valid  = 1'b0;
        bus.s0_addr   = '0;
        bus.s0_data   = '0;
        bus.s1_valid  = 1'b0;
        bus.s1_addr   = '0;
        bus.s1_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_dst   = '0;
        bus.chk_rs1   = '0;
        bus.chk_rs2   = '0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        settle();

        // Reset state.
        check("rst_wr_en",     32'(bus.wr_en), 32'd0);
        check("rst_wr_addr",   32'(bus.wr_addr), 32'd0);
        check("rst_wr_data",   32'(bus.wr_data), 32'd0);
        check("rst_hazard",    32'(bus.hazard), 32'd0);
        check("rst_iss_ready", 32'(bus.iss_ready), 32'd1);

        // 1: lone src0 write to r3.
        bus.s0_valid = 1'b1;
        bus.s0_addr  = 3'd3;
        bus.s0_data  = 8'h5A;
        settle();
        check("t1_s0_ready", 32'(bus.s0_ready), 32'd1);
        check("t1_s1_ready", 32'(bus.s1_ready), 32'd0);
        push(3'd3, 8'h5A);
        cyc();
        bus.s0_valid = 1'b0;
        settle();
        check("t1_wr_en", 32'(bus.wr_en), 32'd1);
        cyc();
        settle();
        check("t1_idle_wr_en", 32'(bus.wr_en), 32'd0);
        check("t1_hold_addr",  32'(bus.wr_addr), 32'd3);

        // 2: both valid after reset -> s0,s1,s0,s1 back to back.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        grants = 4'b1010;  // bit k = 1 means src1 wins cycle k
        bus.s0_valid = 1'b1;
        bus.s0_addr  = 3'd1;
        bus.s0_data  = 8'h10;
        bus.s1_valid = 1'b1;
        bus.s1_addr  = 3'd2;
        bus.s1_data  = 8'h20;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("t2_s0_ready", 32'(bus.s0_ready), 32'(!grants[k]));
            check("t2_s1_ready", 32'(bus.s1_ready), 32'(grants[k]));
            if (k > 0) check("t2_wr_en_b2b", 32'(bus.wr_en), 32'd1);
            if (grants[k]) push(3'd2, bus.s1_data);
            else           push(3'd1, bus.s0_data);
            cyc();
            if (grants[k]) bus.s1_data = bus.s1_data + 8'd1;
            else           bus.s0_data = bus.s0_data + 8'd1;
        end
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        settle();
        check("t2_wr_en_last", 32'(bus.wr_en), 32'd1);

        // 3: issue r5, hazard until s1 commits r5.
        bus.iss_valid = 1'b1;
        bus.iss_dst   = 3'd5;
        settle();
        check("t3_iss_ready_free", 32'(bus.iss_ready), 32'd1);
        cyc();
        bus.iss_valid = 1'b0;
        bus.chk_rs1   = 3'd5;
        settle();
        check("t3_hazard_set",     32'(bus.hazard), 32'd1);
        check("t3_iss_ready_busy", 32'(bus.iss_ready), 32'd0);
        bus.s1_valid = 1'b1;
        bus.s1_addr  = 3'd5;
        bus.s1_data  = 8'h55;
        settle();
        check("t3_s1_ready", 32'(bus.s1_ready), 32'd1);
        push(3'd5, 8'h55);
        cyc();
        bus.s1_valid = 1'b0;
        settle();
        check("t3_hazard_commit_cycle", 32'(bus.hazard), 32'd1);
        cyc();
        settle();
        check("t3_hazard_cleared", 32'(bus.hazard), 32'd0);

        // 4: issue r4 on the edge its (unowned) write commits -> set wins.
        bus.chk_rs1  = 3'd0;
        bus.chk_rs2  = 3'd4;
        bus.s0_valid = 1'b1;
        bus.s0_addr  = 3'd4;
        bus.s0_data  = 8'h44;
        settle();
        check("t4_s0_ready", 32'(bus.s0_ready), 32'd1);
        push(3'd4, 8'h44);
        cyc();
        bus.s0_valid  = 1'b0;
        bus.iss_valid = 1'b1;
        bus.iss_dst   = 3'd4;
        settle();
        check("t4_iss_ready",   32'(bus.iss_ready), 32'd1);
        check("t4_hazard_free", 32'(bus.hazard), 32'd0);
        cyc();
        bus.iss_valid = 1'b0;
        settle();
        check("t4_hazard_set_wins", 32'(bus.hazard), 32'd1);
        cyc();
        settle();
        check("t4_hazard_stays", 32'(bus.hazard), 32'd1);

        // 5: s1 alone three times, then both valid -> s0 first.
        bus.s1_valid = 1'b1;
        bus.s1_addr  = 3'd6;
        bus.s1_data  = 8'h61;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t5_s1_alone", 32'(bus.s1_ready), 32'd1);
            push(3'd6, bus.s1_data);
            cyc();
            bus.s1_data = bus.s1_data + 8'd1;
        end
        bus.s0_valid = 1'b1;
        bus.s0_addr  = 3'd7;
        bus.s0_data  = 8'h70;
        settle();
        check("t5_s0_first", 32'(bus.s0_ready), 32'd1);
        check("t5_s1_waits", 32'(bus.s1_ready), 32'd0);
        push(3'd7, 8'h70);
        cyc();
        bus.s0_valid = 1'b0;
        settle();
        check("t5_s1_next", 32'(bus.s1_ready), 32'd1);
        push(3'd6, 8'h64);
        cyc();
        bus.s1_valid = 1'b0;

        // 6: reset mid-flight with r2, r6 busy and a write accepted.
        bus.iss_valid = 1'b1;
        bus.iss_dst   = 3'd2;
        cyc();
        bus.iss_dst   = 3'd6;
        cyc();
        bus.iss_valid = 1'b0;
        bus.chk_rs1   = 3'd2;
        bus.chk_rs2   = 3'd6;
        settle();
        check("t6_hazard_busy", 32'(bus.hazard), 32'd1);
        bus.s0_valid = 1'b1;
        bus.s0_addr  = 3'd3;
        bus.s0_data  = 8'h99;
        settle();
        check("t6_s0_ready", 32'(bus.s0_ready), 32'd1);
        cyc();
        reset        = 1'b1;
        bus.s0_valid = 1'b0;
        settle();
        check("t6_wr_en_dropped", 32'(bus.wr_en), 32'd0);
        check("t6_hazard_clear",  32'(bus.hazard), 32'd0);
        check("t6_iss_ready",     32'(bus.iss_ready), 32'd1);
        cyc();
        reset = 1'b0;
        bus.chk_rs1 = 3'd4;
        settle();
        check("t6_r4_cleared", 32'(bus.hazard), 32'd0);
        cyc();
        settle();
        check("t6_no_write_after_release", 32'(bus.wr_en), 32'd0);
        bus.s0_valid = 1'b1;
        bus.s0_addr  = 3'd1;
        bus.s0_data  = 8'hB1;
        bus.s1_valid = 1'b1;
        bus.s1_addr  = 3'd5;
        bus.s1_data  = 8'hA5;
        settle();
        check("t6_ptr_s0", 32'(bus.s0_ready), 32'd1);
        push(3'd1, 8'hB1);
        cyc();
        bus.s0_valid = 1'b0;
        settle();
        check("t6_ptr_s1", 32'(bus.s1_ready), 32'd1);
        push(3'd5, 8'hA5);
        cyc();
        bus.s1_valid = 1'b0;

        repeat (3) cyc();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
